alu_muldiv_unit: RTL
====================

// Module: alu_muldiv_unit
// PURPOSE
//  Parametrised RV32I/RV32M execute unit: all base ALU ops plus MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Sits in the EX stage in place of the combinational ALU and decodes the same funct3/funct7 fields.
//  Base ops and divide special cases complete in 1 cycle; iterative mul/div take XLEN cycles.
//  Valid/ready handshake on both sides; flush aborts in-flight work on a pipeline redirect.
// PARAMETERS
//  XLEN      32  operand/result width; power of 2, >= 8; shift amount = B[$clog2(XLEN)-1:0]
//  FAST_MUL  0   1: MUL* ops use a single-cycle '*' (latency 1); 0: iterative shift-add (latency XLEN+1)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  flush      in   1     abort current op, discard any pending result
//  in_valid   in   1     operands/opcode valid
//  in_ready   out  1     unit can accept; transfer when in_valid && in_ready
//  A          in   XLEN  operand 1 (rs1)
//  B          in   XLEN  operand 2 (rs2 or imm)
//  funct3     in   3     operation select
//  funct7     in   7     0x00 base, 0x20 SUB/SRA, 0x01 M-extension
//  out_valid  out  1     Result valid; held until out_ready
//  out_ready  in   1     consumer accepts; transfer when out_valid && out_ready
//  Result     out  XLEN  registered result
//  busy       out  1     high in MUL or DIV state
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, Result=0. Reset overrides flush and all inputs.
//  Decode: funct7==0x01 -> M op: f3 0 MUL(low), 1 MULH(s*s hi), 2 MULHSU(s*u hi), 3 MULHU(u*u hi),
//   4 DIV, 5 DIVU, 6 REM, 7 REMU. Else base op: f3 0 ADD (SUB if f7==0x20), 1 SLL, 2 SLT, 3 SLTU,
//   4 XOR, 5 SRL (SRA if f7==0x20), 6 OR, 7 AND. f7 other than 0x00/0x20/0x01 decodes as 0x00.
//  Arithmetic: all results mod 2^XLEN; high-half mul = bits [2*XLEN-1:XLEN] of 2*XLEN-bit product.
//  FSM: IDLE -> (accept base op, or M op resolved in 1 cycle) -> DONE
//       IDLE -> (accept MUL* with FAST_MUL=0) -> MUL ; IDLE -> (accept DIV/REM general case) -> DIV
//       MUL/DIV: counter counts XLEN iterations (1 bit per cycle), operands latched at accept -> DONE
//       DONE: out_valid=1; on out_ready -> IDLE. Result and out_valid stable while stalled.
//  in_ready = (state==IDLE) && !flush. No accept in DONE (one bubble per op by design).
//  Latency from accept edge to out_valid: 1 cycle base/fast-mul/special div; XLEN+1 cycles iterative.
//  Divide specials (1 cycle, never enter DIV): B==0 -> DIV/DIVU = all ones, REM/REMU = A;
//   signed overflow A==MIN && B==-1 -> DIV = MIN, REM = 0.
//  Signed div: operate on magnitudes; quotient negated if signs differ, remainder takes sign of A.
//  flush: from any state, next state IDLE, out_valid=0, counter cleared; result discarded even if
//   DONE && out_ready in the same cycle (no transfer counted). flush && in_valid: not accepted.
//  Counter wraps never: exits to DONE at exactly XLEN iterations; new op reloads it to 0.
//  busy = (state==MUL || state==DIV).
// TESTING
//  ADD 7+5, SUB f7=0x20 5-7, SRA 0x80000000>>>4 -> 12, 0xFFFFFFFE, 0xF8000000 each 1 cycle after accept
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; FAST_MUL=0 out_valid at accept+33
//  DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2, latency 33
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0, all latency 1
//  DIVU in flight, flush at iteration 10 -> IDLE next cycle, out_valid never rises, next ADD correct
//  out_ready low 5 cycles in DONE -> Result/out_valid held, in_ready=0; rst mid-DIV -> reset values

Source files
------------

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: operand, handshake and flush bundle between the pipeline and alu_muldiv_unit
interface alu_muldiv_if #(parameter int XLEN = 32);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] Result;
  logic [2:0] funct3;
  logic [6:0] funct7;
  modport master (output flush, in_valid, A, B, funct3, funct7, out_ready,
                  input in_ready, out_valid, Result, busy);
  modport slave (input flush, in_valid, A, B, funct3, funct7, out_ready,
                 output in_ready, out_valid, Result, busy);
endinterface

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: RV32I/RV32M execute unit with single-cycle base ops and iterative multiply/divide
module alu_muldiv_unit #(
  parameter int XLEN = 32,
  parameter bit FAST_MUL = 0
) (
  input logic clk,
  input logic rst,
  alu_muldiv_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q;
  logic [2*XLEN-1:0] acc_q, acc_step, prod_fast, mul_p;
  logic [XLEN-1:0] op_q, result_q, base_res, spec_res, fin_res, mag_a, mag_b, a, b, sel;
  logic [XLEN:0] mul_sum, div_r, div_diff;
  logic [SW:0] cnt_q;
  logic [2:0] f3, f3_q;
  logic neg, neg_q, is_m, alt, is_mul, sa, sb, b_zero, ovf;
  // decode, base ALU, operand magnitudes and one iteration step of the shared shift register
  always_comb begin
    a = bus.A;
    b = bus.B;
    f3 = bus.funct3;
    is_m = bus.funct7 == 7'h01;
    alt = bus.funct7 == 7'h20;
    is_mul = !f3[2];
    sa = is_mul ? f3[1:0] != 2'b11 : !f3[0];
    sb = is_mul ? !f3[1] : !f3[0];
    mag_a = (sa && a[XLEN-1]) ? -a : a;
    mag_b = (sb && b[XLEN-1]) ? -b : b;
    neg = is_mul ? ((sa && a[XLEN-1]) ^ (sb && b[XLEN-1])) :
          f3[1] ? (sa && a[XLEN-1]) : (sa && (a[XLEN-1] ^ b[XLEN-1]));
    b_zero = b == '0;
    ovf = !f3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    spec_res = b_zero ? (f3[1] ? a : '1) : (f3[1] ? '0 : a);
    prod_fast = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    prod_fast = neg ? -prod_fast : prod_fast;
    case (f3)
      3'd0: base_res = alt ? a - b : a + b;
      3'd1: base_res = a << b[SW-1:0];
      3'd2: base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      3'd3: base_res = {{(XLEN-1){1'b0}}, a < b};
      3'd4: base_res = a ^ b;
      3'd5: base_res = alt ? XLEN'($signed(a) >>> b[SW-1:0]) : a >> b[SW-1:0];
      3'd6: base_res = a | b;
      default: base_res = a & b;
    endcase
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
    div_r = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_r - {1'b0, op_q};
    acc_step = state_q == MUL ? {mul_sum, acc_q[XLEN-1:1]} :
               {(div_diff[XLEN] ? div_r[XLEN-1:0] : div_diff[XLEN-1:0]), acc_q[XLEN-2:0], !div_diff[XLEN]};
    mul_p = neg_q ? -acc_step : acc_step;
    sel = f3_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    fin_res = state_q == MUL ? (f3_q[1:0] == 2'b00 ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN]) :
              (neg_q ? -sel : sel);
  end
  // control FSM: accept, iterate one bit per cycle, hold the result until it is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      result_q <= '0;
      acc_q <= '0;
      op_q <= '0;
      cnt_q <= '0;
      f3_q <= '0;
      neg_q <= 1'b0;
    end else if (bus.flush) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          f3_q <= f3;
          neg_q <= neg;
          cnt_q <= '0;
          if (!is_m) begin
            result_q <= base_res;
            state_q <= DONE;
          end else if (is_mul && FAST_MUL) begin
            result_q <= f3[1:0] == 2'b00 ? prod_fast[XLEN-1:0] : prod_fast[2*XLEN-1:XLEN];
            state_q <= DONE;
          end else if (is_mul) begin
            acc_q <= {{XLEN{1'b0}}, mag_b};
            op_q <= mag_a;
            state_q <= MUL;
          end else if (b_zero || ovf) begin
            result_q <= spec_res;
            state_q <= DONE;
          end else begin
            acc_q <= {{XLEN{1'b0}}, mag_a};
            op_q <= mag_b;
            state_q <= DIV;
          end
        end
        MUL, DIV: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == (SW+1)'(XLEN-1)) begin
            result_q <= fin_res;
            state_q <= DONE;
          end
        end
        default: if (bus.out_ready) state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = state_q == IDLE && !bus.flush;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = state_q == MUL || state_q == DIV;
  assign bus.Result = result_q;
endmodule
